// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg: shared types and helpers for the pulse_meter block.
//   state_t         - measurement FSM states
//   DEF_SYNC_STAGES - default depth of the sig_in synchronizer
//   sat_val()       - all-ones saturation value for a counter of a given width
package pulse_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;

    function automatic logic [63:0] sat_val(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer for an asynchronous input followed
// by one compare register, producing single-cycle rise/fall pulses.
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   sig   in   asynchronous input
//   rise  out  synchronized 0->1 transition seen this cycle
//   fall  out  synchronized 1->0 transition seen this cycle
module sync_edge_det
    import pulse_meter_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES   // must be at least 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], sig};
            prev   <= sync_q[STAGES-1];
        end
    end

    // Combinational compare: the FSM acts on the edge one clock after the
    // last synchronizer stage changes.
    assign rise =  sync_q[STAGES-1] & ~prev;
    assign fall = ~sync_q[STAGES-1] &  prev;

endmodule

// File: rtl/pulse_meter.sv
// pulse_meter: measures high time, low time, period and phase (relative to
// ref_in rises) of an asynchronous waveform, in clk cycles.
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   en         in   measurement enable
//   sig_in     in   waveform under measurement (asynchronous)
//   ref_in     in   phase reference (synchronous), rising edge = phase zero
//   ton_cyc    out  high time of the last completed period
//   toff_cyc   out  low time of the last completed period
//   period_cyc out  ton_cyc + toff_cyc (one bit wider)
//   phase_cyc  out  ref rise to the sig rise that began that period
//   meas_valid out  one-cycle strobe when the results update
//   timeout    out  sticky: a high or low phase saturated
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    input  logic             ref_in,
    output logic [CNT_W-1:0] ton_cyc,
    output logic [CNT_W-1:0] toff_cyc,
    output logic [CNT_W:0]   period_cyc,
    output logic [CNT_W-1:0] phase_cyc,
    output logic             meas_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_val(CNT_W));
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             sig_rise, sig_fall;
    logic             ref_q, ref_rise;
    logic [CNT_W-1:0] phase_cnt, phase_now;
    logic [CNT_W-1:0] on_cnt, off_cnt, ton_lat, phase_cap;
    state_t           state;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sig_det (
        .clk  (clk),
        .rst  (rst),
        .sig  (sig_in),
        .rise (sig_rise),
        .fall (sig_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ref_q <= 1'b0;
        else     ref_q <= ref_in;
    end
    assign ref_rise = ref_in & ~ref_q;

    // All-ones doubles as "no reference seen since enable".
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   phase_cnt <= SAT;
        else if (!en)              phase_cnt <= SAT;
        else if (ref_rise)         phase_cnt <= '0;
        else if (phase_cnt != SAT) phase_cnt <= phase_cnt + ONE;
    end

    // Phase as it will read after this edge, so a capture on a sig rise is
    // the edge-to-edge distance (0 when ref and sig rise together).
    assign phase_now = ref_rise         ? '0  :
                       (phase_cnt == SAT) ? SAT : phase_cnt + ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            on_cnt     <= '0;
            off_cnt    <= '0;
            ton_lat    <= '0;
            phase_cap  <= '0;
            ton_cyc    <= '0;
            toff_cyc   <= '0;
            period_cyc <= '0;
            phase_cyc  <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!en) begin
                state   <= IDLE;
                timeout <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= SYNC;
                    SYNC: begin
                        if (sig_rise) begin
                            phase_cap <= phase_now;
                            on_cnt    <= ONE;
                            state     <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (sig_fall) begin
                            ton_lat <= on_cnt;
                            off_cnt <= ONE;
                            state   <= LOW;
                        end else if (on_cnt == SAT) begin
                            timeout <= 1'b1;
                            state   <= SYNC;
                        end else begin
                            on_cnt <= on_cnt + ONE;
                        end
                    end
                    LOW: begin
                        if (sig_rise) begin
                            ton_cyc    <= ton_lat;
                            toff_cyc   <= off_cnt;
                            period_cyc <= {1'b0, ton_lat} + {1'b0, off_cnt};
                            phase_cyc  <= phase_cap;
                            meas_valid <= 1'b1;
                            timeout    <= 1'b0;
                            // This rise also opens the next period.
                            phase_cap  <= phase_now;
                            on_cnt     <= ONE;
                            state      <= HIGH;
                        end else if (off_cnt == SAT) begin
                            timeout <= 1'b1;
                            state   <= SYNC;
                        end else begin
                            off_cnt <= off_cnt + ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: drives two meters (16-bit and 8-bit counters) with the same
// stimulus and checks every output every cycle against a timestamp model.
module tb_pulse_meter;

    logic        clk = 1'b0;
    logic        rst, en, sig_in, ref_in;
    logic [15:0] ton16, toff16, ph16;
    logic [16:0] per16;
    logic        val16, to16;
    logic [7:0]  ton8, toff8, ph8;
    logic [8:0]  per8;
    logic        val8, to8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pulse_meter u_dut16 (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in), .ref_in(ref_in),
        .ton_cyc(ton16), .toff_cyc(toff16), .period_cyc(per16),
        .phase_cyc(ph16), .meas_valid(val16), .timeout(to16)
    );

    pulse_meter #(.CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in), .ref_in(ref_in),
        .ton_cyc(ton8), .toff_cyc(toff8), .period_cyc(per8),
        .phase_cyc(ph8), .meas_valid(val8), .timeout(to8)
    );

    // ---------------- reference model (timestamps of detected edges) -------
    int  t = 0;                 // index of the last clk rising edge
    bit  sh[4];                 // raw sig samples at edges t, t-1, t-2, t-3
    bit  rprev, ref_seen;
    int  last_ref;
    int  m_sat[2] = '{65535, 255};
    bit  m_idle[2], m_hasr[2], m_hasf[2];
    int  m_r0[2], m_f[2], m_ph0[2];
    int  e_ton[2], e_toff[2], e_per[2], e_ph[2];
    bit  e_val[2], e_to[2];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) sh[i] = 1'b0;
        rprev = 1'b0; ref_seen = 1'b0; last_ref = 0;
        for (int d = 0; d < 2; d++) begin
            m_idle[d] = 1'b1; m_hasr[d] = 1'b0; m_hasf[d] = 1'b0;
            m_r0[d] = 0; m_f[d] = 0; m_ph0[d] = 0;
            e_ton[d] = 0; e_toff[d] = 0; e_per[d] = 0; e_ph[d] = 0;
            e_val[d] = 1'b0; e_to[d] = 1'b0;
        end
    endtask

    // A sig edge first sampled at edge P is acted upon at edge P+2.
    task automatic model_step(input bit s, input bit r, input bit e);
        bit rise, fall, rr;
        int cap;
        sh[3] = sh[2]; sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = s;
        rise = sh[2] & ~sh[3];
        fall = ~sh[2] & sh[3];
        rr = r & ~rprev;
        rprev = r;
        if (!e) ref_seen = 1'b0;
        else if (rr) begin ref_seen = 1'b1; last_ref = t; end
        for (int d = 0; d < 2; d++) begin
            cap = m_sat[d];
            if (ref_seen && (t - last_ref) < m_sat[d]) cap = t - last_ref;
            e_val[d] = 1'b0;
            if (!e) begin
                m_idle[d] = 1'b1; m_hasr[d] = 1'b0; m_hasf[d] = 1'b0; e_to[d] = 1'b0;
            end else if (m_idle[d]) begin
                m_idle[d] = 1'b0;
            end else if (!m_hasr[d]) begin
                if (rise) begin m_hasr[d] = 1'b1; m_r0[d] = t; m_ph0[d] = cap; end
            end else if (!m_hasf[d]) begin
                if (fall) begin m_hasf[d] = 1'b1; m_f[d] = t; end
                else if (t - m_r0[d] == m_sat[d]) begin e_to[d] = 1'b1; m_hasr[d] = 1'b0; end
            end else begin
                if (rise) begin
                    e_ton[d]  = m_f[d] - m_r0[d];
                    e_toff[d] = t - m_f[d];
                    e_per[d]  = e_ton[d] + e_toff[d];
                    e_ph[d]   = m_ph0[d];
                    e_val[d]  = 1'b1;
                    e_to[d]   = 1'b0;
                    m_r0[d] = t; m_ph0[d] = cap; m_hasf[d] = 1'b0;
                end else if (t - m_f[d] == m_sat[d]) begin
                    e_to[d] = 1'b1; m_hasr[d] = 1'b0; m_hasf[d] = 1'b0;
                end
            end
        end
    endtask

    // ---------------- checking ---------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at edge %0d: got %0d expected %0d", tag, t, obs, exp);
        end
    endtask

    task automatic compare();
        chk("valid16",  32'(val16),  32'(e_val[0]));
        chk("ton16",    32'(ton16),  e_ton[0]);
        chk("toff16",   32'(toff16), e_toff[0]);
        chk("period16", 32'(per16),  e_per[0]);
        chk("phase16",  32'(ph16),   e_ph[0]);
        chk("timeout16",32'(to16),   32'(e_to[0]));
        chk("valid8",   32'(val8),   32'(e_val[1]));
        chk("ton8",     32'(ton8),   e_ton[1]);
        chk("toff8",    32'(toff8),  e_toff[1]);
        chk("period8",  32'(per8),   e_per[1]);
        chk("phase8",   32'(ph8),    e_ph[1]);
        chk("timeout8", 32'(to8),    32'(e_to[1]));
    endtask

    // Called at a negedge; drives inputs, steps one clock, checks at negedge.
    task automatic tick(input logic s, input logic r, input logic e);
        sig_in = s; ref_in = r; en = e;
        @(posedge clk);
        t++;
        model_step(s, r, e);
        @(negedge clk);
        compare();
    endtask

    // n periods of hi/lo cycles; optional 1-cycle ref pulse at offset roff.
    task automatic wave(input int hi, input int lo, input int n, input int roff);
        for (int p = 0; p < n; p++)
            for (int i = 0; i < hi + lo; i++)
                tick(i < hi, i == roff, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int h, l, ro;
        rst = 1'b1; en = 1'b0; sig_in = 1'b0; ref_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        compare();
        rst = 1'b0;
        repeat (3) tick(1'b0, 1'b0, 1'b1);

        // 10-cycle 50% square wave, no reference
        wave(5, 5, 5, -1);
        chk("sq_ton", 32'(ton16), 5);
        chk("sq_toff", 32'(toff16), 5);
        chk("sq_period", 32'(per16), 10);
        chk("sq_noref16", 32'(ph16), 65535);
        chk("sq_noref8", 32'(ph8), 255);

        // 5-cycle 40% duty
        wave(2, 3, 6, -1);
        chk("d40_ton", 32'(ton16), 2);
        chk("d40_toff", 32'(toff16), 3);
        chk("d40_period", 32'(per16), 5);

        // reference pulse so the detected sig rise lands 3 cycles after it
        wave(5, 5, 4, 9);
        chk("phase3", 32'(ph16), 3);

        // single-cycle pulses every 4 cycles
        wave(1, 3, 5, -1);
        chk("p1_ton", 32'(ton8), 1);
        chk("p1_toff", 32'(toff8), 3);
        chk("p1_period", 32'(per8), 4);

        // randomized duty and reference offset
        repeat (6) begin
            h  = $urandom_range(1, 12);
            l  = $urandom_range(1, 12);
            ro = $urandom_range(0, h + l - 1);
            wave(h, l, 3, ro);
        end

        // enable dropped while high: results hold, no strobe
        wave(5, 5, 2, -1);
        repeat (4) tick(1'b1, 1'b0, 1'b1);
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        repeat (4) tick(1'b0, 1'b0, 1'b0);
        chk("en_hold_ton", 32'(ton16), 5);
        chk("en_hold_valid", 32'(val16), 0);
        wave(5, 5, 3, -1);

        // stuck high: 8-bit meter saturates, then recovers
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        repeat (300) tick(1'b1, 1'b0, 1'b1);
        chk("stuck_to8", 32'(to8), 1);
        chk("stuck_to16", 32'(to16), 0);
        wave(5, 5, 4, -1);
        chk("recov_to8", 32'(to8), 0);
        chk("recov_ton8", 32'(ton8), 5);

        // asynchronous reset while low
        wave(5, 5, 2, -1);
        repeat (5) tick(1'b1, 1'b0, 1'b1);
        repeat (4) tick(1'b0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ton16", 32'(ton16), 0);
        chk("arst_period16", 32'(per16), 0);
        chk("arst_phase16", 32'(ph16), 0);
        chk("arst_ton8", 32'(ton8), 0);
        chk("arst_to8", 32'(to8), 0);
        model_reset();
        @(negedge clk);
        compare();
        rst = 1'b0;
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        wave(5, 5, 3, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
